serial_n_bit_adder: RTL and testbench

Bit-serial N-bit adder: the addition counterpart to the team's combinational N-bit subtractor, and the multicycle, low-area companion in the same arithmetic library. It latches two operands on a start strobe and adds them LSB-first, one bit per clock, through a single full-adder cell. It then presents the registered sum and carry-out with a one-cycle done pulse. Typical users are control paths where area matters more than latency, such as accumulators and address stepping.

---
 rtl/arith_pkg.sv | 14 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_n_bit_adder.sv | 111 +++++++++++
 tb/tb_serial_n_bit_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the arithmetic library.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } serial_state_t;

    // Bit-counter width for an n-step serial operation; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; shared by the serial adder and ripple adders.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

// File: rtl/serial_n_bit_adder.sv
// Bit-serial unsigned adder: latches operands on start, adds LSB-first through
// one full-adder cell, and publishes sum/carry with a one-cycle done pulse.
module serial_n_bit_adder
    import arith_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] answer,
    output logic         carry_out
);

    localparam int unsigned CW = cnt_width(N);

    serial_state_t state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  p_sh_q, p_sh_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_d, done_d, carry_out_d;
    logic [N-1:0]  answer_d;
    logic          sum_bit_c, carry_bit_c;
    logic [N-1:0]  p_next_c;

    full_adder_bit u_fa (
        .x     (a_sh_q[0]),
        .y     (b_sh_q[0]),
        .c_in  (c_q),
        .s     (sum_bit_c),
        .c_out (carry_bit_c)
    );

    // Partial sum after this edge: new bit enters at the MSB.
    assign p_next_c = {sum_bit_c, p_sh_q[N-1:1]};

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        p_sh_d      = p_sh_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        busy_d      = busy;
        done_d      = 1'b0;
        answer_d    = answer;
        carry_out_d = carry_out;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = input1;
                    b_sh_d  = input2;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                p_sh_d = p_next_c;
                c_d    = carry_bit_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    answer_d    = p_next_c;
                    carry_out_d = carry_bit_c;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            p_sh_q    <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            answer    <= '0;
            carry_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            p_sh_q    <= p_sh_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            answer    <= answer_d;
            carry_out <= carry_out_d;
        end
    end

endmodule

// File: tb/tb_serial_n_bit_adder.sv
// Scoreboard bench for serial_n_bit_adder at N=8, N=4 and N=13.
module tb_serial_n_bit_adder;

    localparam int NI = 3;

    typedef struct {
        logic [13:0] exp;
        int          due;
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic        start [NI];
    logic [12:0] in1   [NI];
    logic [12:0] in2   [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic [12:0] ans   [NI];
    logic        co    [NI];

    int unsigned nw [NI] = '{8, 4, 13};

    // Reference timing model and scoreboard queues.
    sb_entry_t   q [NI][$];
    logic        m_run  [NI];
    int          m_left [NI];
    logic [13:0] m_pend [NI];
    logic [13:0] m_ans  [NI];
    logic        m_done [NI];
    logic        use_hand [NI];
    logic [13:0] hand_exp [NI];
    int          cyc;

    int checks;
    int failures;
    logic final_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int unsigned NW = (gi == 0) ? 8 : (gi == 1) ? 4 : 13;
        logic [NW-1:0] ans_w;

        serial_n_bit_adder #(.N(NW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[gi]),
            .input1    (in1[gi][NW-1:0]),
            .input2    (in2[gi][NW-1:0]),
            .busy      (busy[gi]),
            .done      (done[gi]),
            .answer    (ans_w),
            .carry_out (co[gi])
        );

        assign ans[gi] = 13'(ans_w);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_run[i]  = 1'b0;
                m_left[i] = 0;
                m_pend[i] = '0;
                m_ans[i]  = '0;
                m_done[i] = 1'b0;
                q[i].delete();
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < NI; i++) begin
                m_done[i] = 1'b0;
                if (!m_run[i]) begin
                    if (start[i]) begin
                        m_pend[i] = use_hand[i] ? hand_exp[i] : (14'(in1[i]) + 14'(in2[i]));
                        q[i].push_back('{exp: m_pend[i], due: cyc + int'(nw[i])});
                        m_run[i]  = 1'b1;
                        m_left[i] = int'(nw[i]);
                    end
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_run[i]  = 1'b0;
                        m_ans[i]  = m_pend[i];
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int idx, input logic [13:0] got, input logic [13:0] want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s[N=%0d] got=0x%0h want=0x%0h t=%0t", name, nw[idx], got, want, $time);
        end
    endtask

    // Monitor: cycle-level output checks plus scoreboard pop on each done.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [13:0] act;
            sb_entry_t   e;
            act = (14'(co[i]) << nw[i]) | 14'(ans[i]);
            check("busy", i, 14'(busy[i]), 14'(m_run[i]));
            check("done", i, 14'(done[i]), 14'(m_done[i]));
            check("hold", i, act, m_ans[i]);
            if (done[i] === 1'b1) begin
                if (q[i].size() == 0) begin
                    check("spurious_done", i, 14'(1), 14'(0));
                end else begin
                    e = q[i].pop_front();
                    check("sum", i, act, e.exp);
                    check("latency", i, 14'(cyc), 14'(e.due));
                end
            end
            if (final_chk) check("missing_done", i, 14'(q[i].size()), 14'(0));
        end
    end

    task automatic go(input int i, input logic [12:0] a, input logic [12:0] b, input logic [13:0] e);
        @(negedge clk);
        start[i]    = 1'b1;
        in1[i]      = a;
        in2[i]      = b;
        use_hand[i] = 1'b1;
        hand_exp[i] = e;
        @(negedge clk);
        start[i]    = 1'b0;
        in1[i]      = ~a;
        in2[i]      = ~b;
        repeat (nw[i] + 1) @(negedge clk);
        use_hand[i] = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        final_chk = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; in1[i] = '0; in2[i] = '0;
            use_hand[i] = 1'b0; hand_exp[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        go(0, 13'h3C, 13'h05, 14'h041);
        go(0, 13'hFF, 13'h01, 14'h100);
        go(0, 13'h80, 13'h80, 14'h100);
        go(0, 13'h00, 13'h00, 14'h000);

        // Start held high with operands changing every cycle.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start[0] = 1'b1;
            in1[0]   = 13'((c * 37 + 11) & 8'hFF);
            in2[0]   = 13'((c * 91 + 200) & 8'hFF);
        end
        @(negedge clk);
        start[0] = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous abort in the middle of a run.
        @(negedge clk);
        start[0] = 1'b1; in1[0] = 13'hA5; in2[0] = 13'h7E;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        go(0, 13'h12, 13'h34, 14'h046);

        go(1, 13'hF, 13'hF, 14'h1E);
        go(1, 13'h9, 13'h3, 14'h0C);
        go(2, 13'h1FFF, 13'h0001, 14'h2000);
        go(2, 13'h1234, 13'h0ABC, 14'h1CF0);

        // Random back-to-back traffic at N=8 and N=13.
        for (int c = 0; c < 14100; c++) begin
            @(negedge clk);
            start[0] = 1'b1;
            start[2] = 1'b1;
            in1[0] = 13'($urandom_range(0, 255));
            in2[0] = 13'($urandom_range(0, 255));
            in1[2] = 13'($urandom_range(0, 8191));
            in2[2] = 13'($urandom_range(0, 8191));
        end
        @(negedge clk);
        start[0] = 1'b0;
        start[2] = 1'b0;
        repeat (20) @(negedge clk);

        final_chk = 1'b1;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
